// File: rtl/chan_event_arbiter_if.sv
// Event stream carrying one channel-activity record per valid/ready handshake.
// The arbiter drives the master side; a logger or monitor sits on the slave side.
interface chan_event_arbiter_if #(
  parameter int ID_W  = 8,
  parameter int SEQ_W = 4
);
  logic             ev_valid;
  logic             ev_ready;
  logic [ID_W-1:0]  ev_id;
  logic             ev_val;
  logic [SEQ_W-1:0] ev_seq;

  modport master (output ev_valid, ev_id, ev_val, ev_seq, input ev_ready);
  modport slave  (input ev_valid, ev_id, ev_val, ev_seq, output ev_ready);
endinterface

// File: rtl/chan_event_arbiter.sv
// Array of NUM_CH registered two-input channels whose value changes are queued
// per channel and serialised round-robin onto a single tagged event stream.
module chan_event_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ID_BASE = 1,
  parameter int ID_W    = 8,
  parameter int OP      = 0,
  parameter int SEQ_W   = 4,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         x,
  input  logic [NUM_CH-1:0]         y,
  output logic [NUM_CH-1:0]         z,
  chan_event_arbiter_if.master      ev,
  output logic [NUM_CH*CNT_W-1:0]   drop_cnt,
  output logic                      drop_any
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] f;
  logic [NUM_CH-1:0] change;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] lat;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] drop_evt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_vld;
  logic              slot_free;
  logic              load;
  logic [SEQ_W-1:0]  seq;
  logic [CNT_W-1:0]  drop_q [NUM_CH];

  // Channel function; unsupported OP codes fall back to AND.
  always_comb begin
    case (OP)
      1:       f = x | y;
      2:       f = x ^ y;
      default: f = x & y;
    endcase
  end

  assign change    = f ^ z;
  assign slot_free = !ev.ev_valid || ev.ev_ready;
  assign load      = slot_free && grant_vld;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int cand;
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_CH;
      if (!grant_vld && pend[cand]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (load) grant_oh[grant_idx] = 1'b1;
  end

  // A change on an already-pending channel loses the previous value unless
  // that channel is being granted in this very cycle.
  assign drop_evt = change & pend & ~grant_oh;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) drop_cnt[i*CNT_W +: CNT_W] = drop_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // lat is a small register file, not RAM, so it is cleared with everything else.
      z           <= '0;
      pend        <= '0;
      lat         <= '0;
      drop_any    <= 1'b0;
      seq         <= '0;
      rr_ptr      <= PTR_W'(NUM_CH - 1);
      ev.ev_valid <= 1'b0;
      ev.ev_id    <= '0;
      ev.ev_val   <= 1'b0;
      ev.ev_seq   <= '0;
      for (int i = 0; i < NUM_CH; i++) drop_q[i] <= '0;
    end else begin
      z <= f;

      for (int i = 0; i < NUM_CH; i++) begin
        if (change[i]) begin
          pend[i] <= 1'b1;
          lat[i]  <= f[i];
        end else if (grant_oh[i]) begin
          pend[i] <= 1'b0;
        end
        if (drop_evt[i] && (drop_q[i] != '1)) drop_q[i] <= drop_q[i] + 1'b1;
      end

      if (|drop_evt) drop_any <= 1'b1;

      if (load) begin
        ev.ev_valid <= 1'b1;
        ev.ev_id    <= ID_W'(ID_BASE) + ID_W'(grant_idx);
        ev.ev_val   <= |(lat & grant_oh);
        ev.ev_seq   <= seq;
        seq         <= seq + 1'b1;
        rr_ptr      <= grant_idx;
      end else if (slot_free) begin
        ev.ev_valid <= 1'b0;
      end
    end
  end

endmodule
